// File: rtl/pwm_pkg.sv
// Shared types and default widths for the complementary PWM generator.
package pwm_pkg;

    typedef enum logic [1:0] {
        DRIVE_LO = 2'd0,
        DEAD_HI  = 2'd1,
        DRIVE_HI = 2'd2,
        DEAD_LO  = 2'd3
    } pwm_state_t;

    localparam int PWM_W    = 11;
    localparam int PWM_DT_W = 6;

endpackage

// File: rtl/pwm_deadband.sv
// Dead-band FSM: turns the raw PWM request into a non-overlapping gate pair,
// holding both sides off for dt_q cycles around every edge.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = PWM_DT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                raw,
    input  logic [DT_WIDTH-1:0] dt_q,
    output logic                PWM_sig,
    output logic                PWM_sig_n
);

    pwm_state_t          state_q, state_d;
    logic [DT_WIDTH-1:0] timer_q, timer_d;
    logic                pwm_sig_q, pwm_sig_d;
    logic                pwm_sig_n_q, pwm_sig_n_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            DRIVE_LO: begin
                if (raw) begin
                    if (dt_q == '0) begin
                        state_d = DRIVE_HI;
                    end else begin
                        state_d = DEAD_HI;
                        timer_d = dt_q - 1'b1;
                    end
                end
            end
            // A request that vanishes mid-gap aborts the turn-on: minimum-pulse rule.
            DEAD_HI: begin
                if (!raw) begin
                    state_d = DRIVE_LO;
                end else if (timer_q == '0) begin
                    state_d = DRIVE_HI;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DRIVE_HI: begin
                if (!raw) begin
                    if (dt_q == '0) begin
                        state_d = DRIVE_LO;
                    end else begin
                        state_d = DEAD_LO;
                        timer_d = dt_q - 1'b1;
                    end
                end
            end
            DEAD_LO: begin
                if (raw) begin
                    state_d = DRIVE_HI;
                end else if (timer_q == '0) begin
                    state_d = DRIVE_LO;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = DRIVE_LO;
        endcase
        pwm_sig_d   = (state_d == DRIVE_HI);
        pwm_sig_n_d = (state_d == DRIVE_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DRIVE_LO;
            timer_q     <= '0;
            pwm_sig_q   <= 1'b0;
            pwm_sig_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pwm_sig_q   <= pwm_sig_d;
            pwm_sig_n_q <= pwm_sig_n_d;
        end
    end

    assign PWM_sig   = pwm_sig_q;
    assign PWM_sig_n = pwm_sig_n_q;

endmodule

// File: rtl/pwm_dt_gen.sv
// Complementary PWM generator: free-running period counter, shadowed duty and
// dead-time (reloaded only at period boundaries or while idle), dead-band stage.
module pwm_dt_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_W,
    parameter int DT_WIDTH = PWM_DT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [WIDTH-1:0]    duty,
    input  logic [DT_WIDTH-1:0] dead_time,
    output logic                PWM_sig,
    output logic                PWM_sig_n,
    output logic                period_start
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    duty_q, duty_d;
    logic [DT_WIDTH-1:0] dt_q, dt_d;
    logic                period_start_q, period_start_d;
    logic                wrap;
    logic                raw;

    always_comb begin
        wrap           = en && (cnt_q == CNT_MAX);
        cnt_d          = en ? cnt_q + 1'b1 : '0;
        duty_d         = duty_q;
        dt_d           = dt_q;
        // Shadow reload only when idle or at the last count, so a write never splits a period.
        if (!en || wrap) begin
            duty_d = duty;
            dt_d   = dead_time;
        end
        period_start_d = wrap;
        raw            = en && (cnt_q < duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            duty_q         <= '0;
            dt_q           <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            dt_q           <= dt_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    pwm_deadband #(
        .DT_WIDTH (DT_WIDTH)
    ) u_deadband (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (raw),
        .dt_q      (dt_q),
        .PWM_sig   (PWM_sig),
        .PWM_sig_n (PWM_sig_n)
    );

endmodule
